wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural integer register file; the consumer end of the MEM/WB pipeline register.
- Selects write-back data from the wb_* bundle, commits it to a 32-entry register file, and serves two combinational read ports to the decode stage with same-cycle write-through bypass.
- Also exports the selected write-back value for EX-stage forwarding, and keeps a retired-write counter.

Parameters:
XLEN, 32, data width of registers and write-back sources
NREGS, 32, number of architectural registers (must equal 2**AW)
AW, 5, register address width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wb_wbsel  input  2  write-back select: 00 none, 01 ALU result, 10 dmem load data, 11 PC+4
wb_dmem_out  input  XLEN  load data from MEM/WB register
wb_alu_res  input  XLEN  ALU result from MEM/WB register
wb_pcp4  input  XLEN  PC+4 from MEM/WB register (link value)
wb_rdaddr  input  AW  destination register index
id_rs1addr  input  AW  decode read port 1 address
id_rs2addr  input  AW  decode read port 2 address
id_rs1data  output  XLEN  read port 1 data (combinational)
id_rs2data  output  XLEN  read port 2 data (combinational)
wb_wdata  output  XLEN  selected write-back value (combinational, for forwarding)
wb_wen  output  1  effective write enable: wbsel!=00 and rdaddr!=0 and rst_n high
wb_retire_cnt  output  32  count of committed register writes

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-low rst_n; sampled only on the rising clk edge.
- Reset: on a clk edge with rst_n=0, all NREGS registers clear to 0 and wb_retire_cnt clears to 0; no write is performed that cycle.
- While rst_n=0, id_rs1data, id_rs2data and wb_wen are forced to 0. wb_wdata still reflects the mux.
- Write data mux (pure combinational): 00 -> 0; 01 -> wb_alu_res; 10 -> wb_dmem_out; 11 -> wb_pcp4.
- Write: on rising edge with wb_wen=1, regs[wb_rdaddr] <= wb_wdata. Latency is 1 cycle to storage.
- x0: writes to index 0 are discarded. wb_wen=0 for rdaddr=0. Reads of index 0 always return 0 and are never bypassed.
- Read: id_rsNdata = regs[id_rsNaddr], except when wb_wen=1 and wb_rdaddr==id_rsNaddr (nonzero); then id_rsNdata = wb_wdata.
  - Write-through bypass gives decode the value being written in the same cycle.
  - Both ports may hit the bypass simultaneously; each port is evaluated independently.
- wb_retire_cnt: increments by 1 on each edge where wb_wen=1. It wraps from 0xFFFFFFFF to 0 silently. Writes to x0 and wbsel=00 do not count.
- No stall/flush inputs: a bubble is encoded upstream as wbsel=00.
- Reset mid-stream: a pending write in the same cycle as rst_n=0 is dropped. The first write after release commits normally on the first edge with rst_n=1.
- No X propagation: stored registers are always defined after the first reset edge.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wbsel=01, rdaddr=5, alu_res=0xDEADBEEF -> reg5 reads 0 after release, wb_retire_cnt=0, wb_wen=0 during reset.
- Mux/write: sel=01 alu=0x11 rd=1; sel=10 dmem=0x22 rd=2; sel=11 pcp4=0x33 rd=3; sel=00 rd=4 -> reads give r1=0x11, r2=0x22, r3=0x33, r4=0; retire_cnt=3.
- x0: wbsel=01, rd=0, alu=0xFFFFFFFF, rs1addr=0 -> wb_wen=0, id_rs1data=0 in the same cycle and after; retire_cnt unchanged.
- Bypass: r7 holds 0xA; write rd=7 alu=0xB with rs1addr=rs2addr=7 -> both ports read 0xB in the same cycle and 0xB afterwards. With sel=00 and rd=7, the ports read the stored value.
- Counter wrap: preload by forcing 0xFFFFFFFE, then 3 valid writes -> counter reads 0xFFFFFFFF, 0x0, 0x1.
- Random regression: 10k random wb_* and read addresses vs. a reference model array -> all reads match every cycle, including simultaneous bypass on both ports.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back bundle and decode read ports of the register file
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [1:0]      wb_wbsel;
  logic [XLEN-1:0] wb_dmem_out;
  logic [XLEN-1:0] wb_alu_res;
  logic [XLEN-1:0] wb_pcp4;
  logic [AW-1:0]   wb_rdaddr;
  logic [AW-1:0]   id_rs1addr;
  logic [AW-1:0]   id_rs2addr;
  logic [XLEN-1:0] id_rs1data;
  logic [XLEN-1:0] id_rs2data;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_wen;
  logic [31:0]     wb_retire_cnt;

  modport master (
    output wb_wbsel, wb_dmem_out, wb_alu_res, wb_pcp4, wb_rdaddr, id_rs1addr, id_rs2addr,
    input  id_rs1data, id_rs2data, wb_wdata, wb_wen, wb_retire_cnt
  );

  modport slave (
    input  wb_wbsel, wb_dmem_out, wb_alu_res, wb_pcp4, wb_rdaddr, id_rs1addr, id_rs2addr,
    output id_rs1data, id_rs2data, wb_wdata, wb_wen, wb_retire_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32-entry register file with write-through bypass
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     retire_cnt_q;
  logic [31:0]     retire_cnt_d;
  logic [XLEN-1:0] wdata;
  logic            wen;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  always_comb begin
    wdata = '0;
    unique case (bus.wb_wbsel)
      2'b01:   wdata = bus.wb_alu_res;
      2'b10:   wdata = bus.wb_dmem_out;
      2'b11:   wdata = bus.wb_pcp4;
      default: wdata = '0;
    endcase
    wen = rst_n && (bus.wb_wbsel != 2'b00) && (bus.wb_rdaddr != '0);
  end

  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (wen) begin
      regs_d[bus.wb_rdaddr] = wdata;
      retire_cnt_d          = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q       <= '{default: '0};
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // wen already excludes x0, so a bypass hit can never return nonzero for index 0
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n) begin
      if (bus.id_rs1addr != '0) begin
        rs1_data = (wen && bus.wb_rdaddr == bus.id_rs1addr) ? wdata : regs_q[bus.id_rs1addr];
      end
      if (bus.id_rs2addr != '0) begin
        rs2_data = (wen && bus.wb_rdaddr == bus.id_rs2addr) ? wdata : regs_q[bus.id_rs2addr];
      end
    end
  end

  assign bus.id_rs1data    = rs1_data;
  assign bus.id_rs2data    = rs2_data;
  assign bus.wb_wdata      = wdata;
  assign bus.wb_wen        = wen;
  assign bus.wb_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized and directed checks of wb_regfile against an array model
module tb_wb_regfile;

  logic clk;
  logic rst_n;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] dmem, input logic [31:0] alu,
                       input logic [31:0] pcp4, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb_wbsel    = sel;
    bus.wb_dmem_out = dmem;
    bus.wb_alu_res  = alu;
    bus.wb_pcp4     = pcp4;
    bus.wb_rdaddr   = rd;
    bus.id_rs1addr  = rs1;
    bus.id_rs2addr  = rs2;
  endtask

  function automatic logic [31:0] exp_wdata();
    case (bus.wb_wbsel)
      2'd1:    return bus.wb_alu_res;
      2'd2:    return bus.wb_dmem_out;
      2'd3:    return bus.wb_pcp4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_wen();
    return rst_n && bus.wb_wbsel != 2'd0 && bus.wb_rdaddr != 5'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (exp_wen() && bus.wb_rdaddr == a) return exp_wdata();
    return model_regs[a];
  endfunction

  // Called at negedge with inputs already driven; checks combinational outputs, then advances one edge.
  task automatic step(input string tag);
    #1;
    check({tag, ".wdata"}, bus.wb_wdata, exp_wdata());
    check({tag, ".wen"}, {31'd0, bus.wb_wen}, {31'd0, exp_wen()});
    check({tag, ".rs1"}, bus.id_rs1data, exp_read(bus.id_rs1addr));
    check({tag, ".rs2"}, bus.id_rs2data, exp_read(bus.id_rs2addr));
    check({tag, ".cnt"}, bus.wb_retire_cnt, model_cnt);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt = 32'd0;
    end else if (bus.wb_wbsel != 2'd0 && bus.wb_rdaddr != 5'd0) begin
      model_regs[bus.wb_rdaddr] = exp_wdata();
      model_cnt = model_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_cnt = 32'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    wrap_exp[0] = 32'hFFFF_FFFF;
    wrap_exp[1] = 32'h0000_0000;
    wrap_exp[2] = 32'h0000_0001;

    // Reset with a pending write to r5 that must be dropped
    rst_n = 1'b0;
    drive(2'd1, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd5, 5'd5, 5'd5);
    @(posedge clk);
    @(negedge clk);
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0);
    step("post_rst");

    // Each mux source, plus a bubble
    drive(2'd1, 32'd0, 32'h11, 32'd0, 5'd1, 5'd0, 5'd0); step("sel_alu");
    drive(2'd2, 32'h22, 32'd0, 32'd0, 5'd2, 5'd1, 5'd0); step("sel_dmem");
    drive(2'd3, 32'd0, 32'd0, 32'h33, 5'd3, 5'd1, 5'd2); step("sel_pcp4");
    drive(2'd0, 32'd0, 32'h44, 32'd0, 5'd4, 5'd3, 5'd4); step("sel_none");
    drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd2);
    #1;
    check("r1", bus.id_rs1data, 32'h11);
    check("r2", bus.id_rs2data, 32'h22);
    bus.id_rs1addr = 5'd3; bus.id_rs2addr = 5'd4;
    #1;
    check("r3", bus.id_rs1data, 32'h33);
    check("r4", bus.id_rs2data, 32'h0);
    check("cnt3", bus.wb_retire_cnt, 32'd3);
    @(negedge clk);

    // x0 writes are discarded
    drive(2'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0); step("x0_wr");
    drive(2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0); step("x0_rd");
    check("x0_cnt", bus.wb_retire_cnt, 32'd3);

    // Bypass on both ports
    drive(2'd1, 32'd0, 32'hA, 32'd0, 5'd7, 5'd0, 5'd0); step("r7_a");
    drive(2'd1, 32'd0, 32'hB, 32'd0, 5'd7, 5'd7, 5'd7);
    #1;
    check("byp_rs1", bus.id_rs1data, 32'hB);
    check("byp_rs2", bus.id_rs2data, 32'hB);
    step("byp");
    drive(2'd0, 32'd0, 32'hC, 32'd0, 5'd7, 5'd7, 5'd7);
    #1;
    check("nobyp_rs1", bus.id_rs1data, 32'hB);
    check("nobyp_rs2", bus.id_rs2data, 32'hB);
    step("nobyp");

    // Counter wrap from a preloaded value
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    model_cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 32'd0, 32'h100 + k, 32'd0, 5'(k + 8), 5'd0, 5'd0);
      step("wrap");
      check("wrap_val", bus.wb_retire_cnt, wrap_exp[k]);
    end

    // Random regression, with biased address hits and occasional mid-stream reset
    for (int n = 0; n < 10000; n++) begin
      logic [4:0] rd;
      logic [4:0] r1;
      logic [4:0] r2;
      rd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 299) != 0);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, rd, r1, r2);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
